fsm_4s1i2o_moore_comb: RTL and testbench

//   Combinational next-state and output logic for a 4-state, 1-input,
//   2-output Moore FSM, defined by a fixed state transition table.
//   The state register lives in the parent. This block decodes the

---
 rtl/fsm_4s1i2o_moore_comb.sv | 72 +++++++
 tb/tb_fsm_4s1i2o_moore_comb.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fsm_4s1i2o_moore_comb.sv
// Next-state and Moore output decode for a fixed 4-state, 1-input, 2-output FSM.
// The state register lives in the parent. clk and reset exist only to keep the
// port list uniform with sibling blocks and do not affect any output.
module fsm_4s1i2o_moore_comb (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] state,
   input  logic       in_,
   output logic [1:0] state_next,
   output logic       out0,
   output logic       out1
);

   localparam int unsigned STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_A = 2'd0,
      ST_B = 2'd1,
      ST_C = 2'd2,
      ST_D = 2'd3
   } state_t;

   state_t cur_state;
   state_t nxt_state;

   // clk and reset are intentionally unused; fold them into a named sink.
   logic unused_ports;
   assign unused_ports = &{1'b0, clk, reset};

   // View the parent's raw state bits through the enum.
   assign cur_state = state_t'(state);

   // Transition table and Moore outputs; defaults first so nothing latches.
   always_comb begin
      nxt_state = ST_A;
      out0      = 1'b0;
      out1      = 1'b0;
      case (cur_state)
         ST_A: begin
            nxt_state = in_ ? ST_B : ST_A;
         end
         ST_B: begin
            nxt_state = in_ ? ST_B : ST_C;
            out1      = 1'b1;
         end
         ST_C: begin
            nxt_state = in_ ? ST_D : ST_A;
            out0      = 1'b1;
         end
         ST_D: begin
            nxt_state = in_ ? ST_B : ST_C;
            out0      = 1'b1;
            out1      = 1'b1;
         end
         default: begin
            nxt_state = ST_A;
         end
      endcase
   end

   assign state_next = STATE_W'(nxt_state);

`ifndef SYNTHESIS
   // Outputs must never go unknown while the decode inputs are known.
   always_comb begin
      if (!$isunknown({state, in_})) begin
         assert (!$isunknown({state_next, out0, out1}));
      end
   end
`endif

endmodule

// File: tb/tb_fsm_4s1i2o_moore_comb.sv
// Self-checking bench for fsm_4s1i2o_moore_comb: table sweep, directed corner
// sequences, closed-loop register wrap and randomized model comparison.
module tb_fsm_4s1i2o_moore_comb;

   logic       clk;
   logic       reset;
   logic [1:0] drv_state;
   logic       in_;
   logic [1:0] state;
   logic [1:0] state_next;
   logic       out0;
   logic       out1;

   // Closed-loop wrap: a register that resets to A and follows state_next.
   logic       loop_en;
   logic [1:0] loop_q;

   int checks;
   int failures;

   typedef struct {
      logic [1:0] st;
      logic       in;
      logic [1:0] exp_next;
      logic       exp_out0;
      logic       exp_out1;
   } vec_t;

   vec_t vecs[8];

   fsm_4s1i2o_moore_comb dut (
      .clk        (clk),
      .reset      (reset),
      .state      (state),
      .in_        (in_),
      .state_next (state_next),
      .out0       (out0),
      .out1       (out1)
   );

   assign state = loop_en ? loop_q : drv_state;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) loop_q <= 2'd0;
      else        loop_q <= state_next;
   end

   // Reference model: next state from the transition table as a lookup list,
   // outputs from the state number (out0 set for C/D, out1 set for B/D).
   function automatic logic [1:0] model_next(input int s, input int i);
      int tab[8];
      tab = '{0, 1, 2, 1, 0, 3, 2, 1};
      return 2'(tab[s * 2 + i]);
   endfunction

   function automatic logic model_out0(input int s);
      return (s >= 2);
   endfunction

   function automatic logic model_out1(input int s);
      return (s % 2) == 1;
   endfunction

   task automatic check(input string name, input logic [1:0] en,
                        input logic e0, input logic e1);
      checks++;
      if (state_next !== en || out0 !== e0 || out1 !== e1) begin
         failures++;
         $display("FAIL %s: got next=%0d out0=%b out1=%b, want next=%0d out0=%b out1=%b",
                  name, state_next, out0, out1, en, e0, e1);
      end
   endtask

   task automatic apply(input logic [1:0] s, input logic i);
      drv_state = s;
      in_       = i;
      #8;
   endtask

   initial begin
      logic [1:0] exp_seq[4];
      logic       in_seq[4];
      logic [1:0] rs;
      logic       ri;

      checks    = 0;
      failures  = 0;
      loop_en   = 1'b0;
      reset     = 1'b0;
      drv_state = 2'd0;
      in_       = 1'b0;
      #8;
      check("reset_state_A", 2'd0, 1'b0, 1'b0);
      reset = 1'b1;

      vecs[0] = '{2'd0, 1'b0, 2'd0, 1'b0, 1'b0};
      vecs[1] = '{2'd0, 1'b1, 2'd1, 1'b0, 1'b0};
      vecs[2] = '{2'd1, 1'b0, 2'd2, 1'b0, 1'b1};
      vecs[3] = '{2'd1, 1'b1, 2'd1, 1'b0, 1'b1};
      vecs[4] = '{2'd2, 1'b0, 2'd0, 1'b1, 1'b0};
      vecs[5] = '{2'd2, 1'b1, 2'd3, 1'b1, 1'b0};
      vecs[6] = '{2'd3, 1'b0, 2'd2, 1'b1, 1'b1};
      vecs[7] = '{2'd3, 1'b1, 2'd1, 1'b1, 1'b1};

      // Exhaustive sweep of all 8 (state, in_) pairs.
      for (int k = 0; k < 8; k++) begin
         apply(vecs[k].st, vecs[k].in);
         check($sformatf("sweep_s%0d_i%0d", vecs[k].st, vecs[k].in),
               vecs[k].exp_next, vecs[k].exp_out0, vecs[k].exp_out1);
      end

      // Moore property: outputs hold while in_ toggles in state D.
      apply(2'd3, 1'b0);
      check("moore_D_in0", 2'd2, 1'b1, 1'b1);
      apply(2'd3, 1'b1);
      check("moore_D_in1", 2'd1, 1'b1, 1'b1);

      // Self-loops.
      apply(2'd0, 1'b0);
      check("selfloop_A", 2'd0, 1'b0, 1'b0);
      apply(2'd1, 1'b1);
      check("selfloop_B", 2'd1, 1'b0, 1'b1);

      // Reset insensitivity.
      reset = 1'b0;
      apply(2'd1, 1'b0);
      check("reset_low_B0", 2'd2, 1'b0, 1'b1);
      reset = 1'b1;
      apply(2'd1, 1'b0);
      check("reset_high_B0", 2'd2, 1'b0, 1'b1);

      // Clock insensitivity: hold (3,0) across several clock edges.
      apply(2'd3, 1'b0);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         check($sformatf("clk_rise_%0d", k), 2'd2, 1'b1, 1'b1);
         @(negedge clk); #1;
         check($sformatf("clk_fall_%0d", k), 2'd2, 1'b1, 1'b1);
      end

      // Closed loop: in_ = 1,0,1,0 walks A->B->C->D->C.
      in_seq  = '{1'b1, 1'b0, 1'b1, 1'b0};
      exp_seq = '{2'd1, 2'd2, 2'd3, 2'd2};
      @(negedge clk);
      loop_en = 1'b1;
      reset   = 1'b0;
      #1;
      checks++;
      if (loop_q !== 2'd0) begin
         failures++;
         $display("FAIL loop_reset: got state=%0d want 0", loop_q);
      end
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in_ = in_seq[k];
         @(posedge clk); #1;
         checks++;
         if (loop_q !== exp_seq[k]) begin
            failures++;
            $display("FAIL loop_step_%0d: got state=%0d want %0d", k, loop_q, exp_seq[k]);
         end
         @(negedge clk);
      end
      loop_en = 1'b0;

      // Randomized stimulus, including reset, against the reference model.
      for (int k = 0; k < 200; k++) begin
         rs    = 2'($urandom_range(3, 0));
         ri    = 1'($urandom_range(1, 0));
         reset = 1'($urandom_range(1, 0));
         drv_state = rs;
         in_       = ri;
         #($urandom_range(7, 2));
         check($sformatf("rand_%0d_s%0d_i%0d", k, rs, ri),
               model_next(int'(rs), int'(ri)), model_out0(int'(rs)),
               model_out1(int'(rs)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
